branch_pc_unit: RTL

- Consumer end of the execute stage. Takes the branch target, ALU flags and flag-update strobe from execute, and owns the architectural NZVC flag register and the program counter.
- Resolves unconditional branches (B), conditional branches (B.cond) and compare-and-branch-on-zero (CBZ).
- Advances PC by 4 or redirects it to the branch target.
- On a taken branch, runs a flush sequence that squashes wrong-path instructions for a fixed number of cycles.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/cond_eval.sv | 38 +++
 rtl/branch_pc_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch / PC unit.
//   br_type_e  : branch kind presented by execute
//   COND_*     : 4-bit ARM condition codes
//   fl_state_e : flush FSM states
package branch_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_COND = 2'b10,
    BR_CBZ  = 2'b11
  } br_type_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic {
    FL_RUN   = 1'b0,
    FL_FLUSH = 1'b1
  } fl_state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator.
//   cond       : condition code
//   n, z, v, c : architectural flags
//   cond_true  : condition holds
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  input  logic       c,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_HS: cond_true = c;
      COND_LO: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c & !z;
      COND_LS: cond_true = !(c & !z);
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z & (n == v);
      COND_LE: cond_true = !(!z & (n == v));
      // AL and the 4'b1111 encoding both execute unconditionally.
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Branch resolution, NZVC flag register and program counter.
//   clk, reset        : clock, asynchronous active-high reset
//   stall             : holds all state for the cycle
//   br_type, cond     : branch kind and condition code
//   br_target         : redirect address
//   alu_*             : live ALU flags; update loads them at the next edge
//   PC, flag_*        : architectural state
//   taken             : branch was taken at the last edge
//   flush             : wrong-path squash in progress
module branch_pc_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  br_type,
  input  logic [3:0]  cond,
  input  logic [63:0] br_target,
  input  logic        alu_zero,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  input  logic        update,
  output logic [63:0] PC,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_c,
  output logic        taken,
  output logic        flush
);
  import branch_pkg::*;

  localparam logic [2:0] FlushInit = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

  logic [63:0] pc_q, pc_d;
  logic [3:0]  nzvc_q, nzvc_d;
  logic        taken_q, taken_d;
  fl_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        cond_true;
  logic        take_now;

  // Registered flags only: an update in this cycle is not visible to B.cond until next cycle.
  cond_eval u_cond_eval (
    .cond      (cond),
    .n         (nzvc_q[3]),
    .z         (nzvc_q[2]),
    .v         (nzvc_q[1]),
    .c         (nzvc_q[0]),
    .cond_true (cond_true)
  );

  always_comb begin
    take_now = 1'b0;
    case (br_type_e'(br_type))
      BR_B:    take_now = 1'b1;
      BR_COND: take_now = cond_true;
      BR_CBZ:  take_now = alu_zero;  // live ALU result, not the flag register
      default: take_now = 1'b0;
    endcase
    if (state_q == FL_FLUSH) begin
      take_now = 1'b0;
    end
  end

  always_comb begin
    pc_d    = take_now ? br_target : pc_q + 64'd4;
    nzvc_d  = nzvc_q;
    taken_d = take_now;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (update && state_q == FL_RUN) begin
      nzvc_d = {alu_negative, alu_zero, alu_overflow, alu_carry_out};
    end
    case (state_q)
      FL_RUN: begin
        if (take_now && FLUSH_CYCLES > 0) begin
          state_d = FL_FLUSH;
          cnt_d   = FlushInit;
        end
      end
      FL_FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = FL_RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = FL_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      nzvc_q  <= 4'b0000;
      taken_q <= 1'b0;
      state_q <= FL_RUN;
      cnt_q   <= 3'd0;
    end else if (!stall) begin
      pc_q    <= pc_d;
      nzvc_q  <= nzvc_d;
      taken_q <= taken_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC     = pc_q;
  assign flag_n = nzvc_q[3];
  assign flag_z = nzvc_q[2];
  assign flag_v = nzvc_q[1];
  assign flag_c = nzvc_q[0];
  assign taken  = taken_q;
  assign flush  = (state_q == FL_FLUSH);

endmodule
